multiplier8bits_seq: RTL and testbench
======================================

MULTIPLIER8BITS_SEQ -- requirements
Module: multiplier8bits_seq

Interface
REQ-001 The block SHALL use one clock, clk; reset is asynchronous and active-high, reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 signed_mode  input  1  1 = two's-complement (IMUL), 0 = unsigned (MUL); sampled with start.
REQ-006 multiplicand  input  8  operand A; sampled with start.
REQ-007 multiplier  input  8  operand B; sampled with start.
REQ-008 product  output  16  registered result; holds last result until next completion.
REQ-009 overflow  output  1  registered; upper byte significant (8086 CF/OF sense).
REQ-010 busy  output  1  high from accept edge until return to IDLE.
REQ-011 done  output  1  registered one-cycle completion pulse.

Function
REQ-012 States SHALL be IDLE, RUN, FIX, DONE; encoding free.
REQ-013 IDLE with start=1 at edge E0 SHALL: latch |A|,|B| (negate if signed_mode and bit7=1; -128 -> magnitude 0x80), latch neg = signed_mode & (A[7]^B[7]), clear 16-bit accumulator and 3-bit step counter, set busy=1, go to RUN.
REQ-014 IDLE with start=0 SHALL hold all state.
REQ-015 RUN SHALL perform one unsigned shift-add step per edge (add shifted magnitude A when current B bit is 1), exactly 8 steps, edges E1..E8, then go to FIX.
REQ-016 Step counter SHALL wrap 7->0 on the 8th step, and that wrap SHALL be the RUN->FIX condition.
REQ-017 FIX at edge E9 SHALL load product = neg ? (0 - acc) : acc, mod 2^16, load overflow, set done=1, go to DONE.
REQ-018 Unsigned overflow SHALL be 1 iff product[15:8] != 0x00.
REQ-019 Signed overflow SHALL be 1 iff product[15:8] != {8{product[7]}}.
REQ-020 DONE at edge E10 SHALL clear done and busy and go to IDLE; done high exactly one cycle (E9 to E10).
REQ-021 Latency SHALL be fixed: done visible 9 cycles after the accept edge, independent of operand values.
REQ-022 start while busy=1 (RUN, FIX, DONE) SHALL be ignored, not queued.
REQ-023 Input changes while busy=1 SHALL NOT affect the in-flight result.
REQ-024 Earliest next accept SHALL be edge E11 (IDLE after DONE); product/overflow SHALL hold their values until the next FIX.
REQ-025 Zero operands SHALL follow the normal 9-cycle path; no early exit.

Reset
REQ-026 reset=1 SHALL immediately force IDLE, product=0x0000, overflow=0, busy=0, done=0, clear internal registers.
REQ-027 reset asserted mid-operation SHALL abort the operation with no done pulse; first edge after release SHALL accept start normally.
REQ-028 reset SHALL take priority over start on the same edge.

Verification
REQ-029 unsigned 3*5, start at E0 -> done high E9-E10 only, product=0x000F, overflow=0, busy E0-E10.
REQ-030 unsigned 0xFF*0xFF -> product=0xFE01, overflow=1.
REQ-031 signed 0xFD(-3)*0x07 -> product=0xFFEB(-21), overflow=0; signed 0x80*0x80 -> product=0x4000, overflow=1.
REQ-032 start re-pulsed at E3 with operands changed to 0x11*0x22 during a 3*5 run -> single done at E9, product=0x000F, no second done.
REQ-033 reset pulsed between E4 and E5 of a run -> busy=0, done=0, product=0x0000 at once; no done follows; new 2*2 unsigned run then gives 0x0004 after 9 cycles.
REQ-034 back-to-back: start held high continuously -> accepts at E0 and E11, done pulses at E9 and E20.

Source files
------------

// File: rtl/multiplier8bits_seq_if.sv
// Operand/result bundle for the sequential 8x8 multiplier.
// The requester drives start and the operands; the multiplier returns product, overflow, busy and done.
// There is no stall path: start is accepted only while the multiplier is idle, and is dropped otherwise.
interface multiplier8bits_seq_if;
  logic        start;
  logic        signed_mode;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [15:0] product;
  logic        overflow;
  logic        busy;
  logic        done;

  // Requester side: issues operations and observes results
  modport master (
    output start,
    output signed_mode,
    output multiplicand,
    output multiplier,
    input  product,
    input  overflow,
    input  busy,
    input  done
  );

  // Multiplier side: consumes operations and returns results
  modport slave (
    input  start,
    input  signed_mode,
    input  multiplicand,
    input  multiplier,
    output product,
    output overflow,
    output busy,
    output done
  );
endinterface

// File: rtl/multiplier8bits_seq.sv
// Sequential 8x8 shift-add multiplier, unsigned (MUL) or two's-complement (IMUL), with 8086-style overflow.
// Latency: done pulses exactly 9 cycles after the accept edge, whatever the operand values.
// Backpressure: none; start is sampled only in IDLE and ignored (not queued) while busy.
module multiplier8bits_seq (
  input  logic                        clk,
  input  logic                        reset,
  multiplier8bits_seq_if.slave        bus
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Operation state
  logic [1:0]  state_q,    state_d;
  logic [7:0]  a_mag_q,    a_mag_d;     // |multiplicand| captured at accept
  logic [7:0]  b_mag_q,    b_mag_d;     // |multiplier| captured at accept
  logic        neg_q,      neg_d;       // result sign must be flipped at FIX
  logic        mode_q,     mode_d;      // signed_mode captured at accept
  logic [15:0] acc_q,      acc_d;       // unsigned partial-product accumulator
  logic [2:0]  cnt_q,      cnt_d;       // shift-add step index (bit of B)

  // Architecturally visible results
  logic [15:0] product_q,  product_d;
  logic        overflow_q, overflow_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;

  // Datapath helpers
  logic [2:0]  cnt_inc;
  logic        cnt_wrap;
  logic [15:0] addend;
  logic [15:0] fix_prod;
  logic        fix_ovf;

  // Magnitude of an operand; -128 maps to 0x80, which the 8-bit field holds exactly
  function automatic logic [7:0] magnitude(input logic [7:0] v, input logic sgn);
    return (sgn && v[7]) ? (~v + 8'd1) : v;
  endfunction

  assign cnt_inc  = cnt_q + 3'd1;
  // The eighth step is the one whose increment rolls 7 back to 0; that roll ends RUN
  assign cnt_wrap = (cnt_inc == 3'd0);
  assign addend   = 16'({8'h00, a_mag_q}) << cnt_q;

  // Sign fix-up and overflow evaluation of the finished accumulator
  always_comb begin
    fix_prod = neg_q ? (16'd0 - acc_q) : acc_q;
    if (mode_q) begin
      fix_ovf = (fix_prod[15:8] != {8{fix_prod[7]}});
    end else begin
      fix_ovf = (fix_prod[15:8] != 8'h00);
    end
  end

  // Next-state logic for the FSM and all operation registers
  always_comb begin
    state_d    = state_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    neg_d      = neg_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      ST_IDLE: begin
        // Operands are captured here only, so later input wiggles cannot disturb the run
        if (bus.start) begin
          a_mag_d = magnitude(bus.multiplicand, bus.signed_mode);
          b_mag_d = magnitude(bus.multiplier, bus.signed_mode);
          neg_d   = bus.signed_mode & (bus.multiplicand[7] ^ bus.multiplier[7]);
          mode_d  = bus.signed_mode;
          acc_d   = 16'h0000;
          cnt_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // One step per cycle, always eight of them, so latency never depends on the data
        if (b_mag_q[cnt_q]) begin
          acc_d = acc_q + addend;
        end
        cnt_d = cnt_inc;
        if (cnt_wrap) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        product_d  = fix_prod;
        overflow_d = fix_ovf;
        done_d     = 1'b1;
        state_d    = ST_DONE;
      end

      ST_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and operand registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_mag_q <= 8'h00;
      b_mag_q <= 8'h00;
      neg_q   <= 1'b0;
      mode_q  <= 1'b0;
      acc_q   <= 16'h0000;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      neg_q   <= neg_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result and status registers; product/overflow hold until the next FIX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product_q  <= 16'h0000;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      product_q  <= product_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.product  = product_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_multiplier8bits_seq.sv
// Directed bench for multiplier8bits_seq: timing trace, MUL/IMUL results, ignored start, mid-run reset.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
// Every wait for done is bounded and a timeout shows up as a wrong done cycle.
module tb_multiplier8bits_seq;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  multiplier8bits_seq_if bus ();

  multiplier8bits_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and return the cycle (relative to accept edge) at which done was seen.
  // Leaves the DUT back in IDLE, ready to accept on the next edge.
  task automatic run_op(input logic mode, input logic [7:0] a, input logic [7:0] b,
                        output int done_cyc);
    done_cyc             = -1;
    bus.signed_mode      = mode;
    bus.multiplicand     = a;
    bus.multiplier       = b;
    bus.start            = 1'b1;
    @(posedge clk); #1;
    bus.start            = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.multiplicand = 8'h00; bus.multiplier = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.product !== 16'h0000) begin errors++; $display("FAIL reset_product got=%h want=0000", bus.product); end
    checks++;
    if ({bus.overflow, bus.busy, bus.done} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got ovf/busy/done=%b want=000", {bus.overflow, bus.busy, bus.done});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // 3*5 unsigned with a full per-cycle trace of busy and done
  task automatic test_timing_3x5();
    int bad_busy;
    int bad_done;
    bad_busy = 0; bad_done = 0;
    bus.signed_mode = 1'b0; bus.multiplicand = 8'd3; bus.multiplier = 8'd5; bus.start = 1'b1;
    @(posedge clk); #1;              // E0
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept got=%b want=1", bus.busy); end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (bus.busy !== ((cyc < 10) ? 1'b1 : 1'b0)) bad_busy++;
      if (bus.done !== ((cyc == 9) ? 1'b1 : 1'b0)) bad_done++;
    end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL busy_trace bad_cycles=%0d want=0", bad_busy); end
    checks++;
    if (bad_done != 0) begin errors++; $display("FAIL done_trace bad_cycles=%0d want=0", bad_done); end
    checks++;
    if ({bus.overflow, bus.product} !== {1'b0, 16'h000F}) begin
      errors++; $display("FAIL mul_3x5 got=%b/%h want=0/000F", bus.overflow, bus.product);
    end
  endtask

  task automatic test_unsigned();
    int dc;
    run_op(1'b0, 8'hFF, 8'hFF, dc);
    checks++;
    if (dc != 9) begin errors++; $display("FAIL ff_latency got=%0d want=9", dc); end
    checks++;
    if ({bus.overflow, bus.product} !== {1'b1, 16'hFE01}) begin
      errors++; $display("FAIL mul_ffxff got=%b/%h want=1/FE01", bus.overflow, bus.product);
    end
    run_op(1'b0, 8'h10, 8'h10, dc);
    checks++;
    if ({bus.overflow, bus.product} !== {1'b1, 16'h0100}) begin
      errors++; $display("FAIL mul_10x10 got=%b/%h want=1/0100", bus.overflow, bus.product);
    end
    run_op(1'b0, 8'h0F, 8'h11, dc);
    checks++;
    if ({bus.overflow, bus.product} !== {1'b0, 16'h00FF}) begin
      errors++; $display("FAIL mul_0fx11 got=%b/%h want=0/00FF", bus.overflow, bus.product);
    end
  endtask

  task automatic test_signed();
    int dc;
    run_op(1'b1, 8'hFD, 8'h07, dc);
    checks++;
    if ({bus.overflow, bus.product} !== {1'b0, 16'hFFEB}) begin
      errors++; $display("FAIL imul_m3x7 got=%b/%h want=0/FFEB", bus.overflow, bus.product);
    end
    run_op(1'b1, 8'h80, 8'h80, dc);
    checks++;
    if (dc != 9) begin errors++; $display("FAIL imul_latency got=%0d want=9", dc); end
    checks++;
    if ({bus.overflow, bus.product} !== {1'b1, 16'h4000}) begin
      errors++; $display("FAIL imul_80x80 got=%b/%h want=1/4000", bus.overflow, bus.product);
    end
    run_op(1'b1, 8'h80, 8'h01, dc);
    checks++;
    if ({bus.overflow, bus.product} !== {1'b0, 16'hFF80}) begin
      errors++; $display("FAIL imul_m128x1 got=%b/%h want=0/FF80", bus.overflow, bus.product);
    end
    run_op(1'b1, 8'h7F, 8'h7F, dc);
    checks++;
    if ({bus.overflow, bus.product} !== {1'b1, 16'h3F01}) begin
      errors++; $display("FAIL imul_7fx7f got=%b/%h want=1/3F01", bus.overflow, bus.product);
    end
    run_op(1'b1, 8'hFF, 8'hFF, dc);
    checks++;
    if ({bus.overflow, bus.product} !== {1'b0, 16'h0001}) begin
      errors++; $display("FAIL imul_m1xm1 got=%b/%h want=0/0001", bus.overflow, bus.product);
    end
  endtask

  // Zero operands take the full path, and results hold while inputs wander afterwards
  task automatic test_zero_and_hold();
    int dc;
    int bad_hold;
    run_op(1'b0, 8'h00, 8'h55, dc);
    checks++;
    if (dc != 9) begin errors++; $display("FAIL zero_latency got=%0d want=9", dc); end
    checks++;
    if ({bus.overflow, bus.product} !== {1'b0, 16'h0000}) begin
      errors++; $display("FAIL mul_0x55 got=%b/%h want=0/0000", bus.overflow, bus.product);
    end
    run_op(1'b0, 8'h0C, 8'h0B, dc);
    bad_hold = 0;
    for (int i = 0; i < 6; i++) begin
      bus.multiplicand = 8'(i * 37);
      bus.multiplier   = 8'(i * 91);
      @(posedge clk); #1;
      if (bus.product !== 16'h0084) bad_hold++;
    end
    checks++;
    if (bad_hold != 0) begin errors++; $display("FAIL result_hold bad_cycles=%0d want=0", bad_hold); end
  endtask

  // start re-pulsed at E3 with new operands must be ignored
  task automatic test_ignore_start();
    int n_done;
    int first_done;
    n_done = 0; first_done = -1;
    bus.signed_mode = 1'b0; bus.multiplicand = 8'd3; bus.multiplier = 8'd5; bus.start = 1'b1;
    @(posedge clk); #1;              // E0
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      if (cyc == 3) begin
        bus.start = 1'b1; bus.multiplicand = 8'h11; bus.multiplier = 8'h22;
      end
      @(posedge clk); #1;
      if (cyc == 3) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = cyc;
      end
    end
    checks++;
    if (n_done != 1 || first_done != 9) begin
      errors++; $display("FAIL ignore_start dones=%0d first=%0d want=1 at 9", n_done, first_done);
    end
    checks++;
    if (bus.product !== 16'h000F) begin errors++; $display("FAIL ignore_start_product got=%h want=000F", bus.product); end
  endtask

  // Reset pulsed between E4 and E5 aborts the run; the next op works normally
  task automatic test_reset_mid();
    int n_done;
    int dc;
    n_done = 0;
    bus.signed_mode = 1'b0; bus.multiplicand = 8'd9; bus.multiplier = 8'd9; bus.start = 1'b1;
    @(posedge clk); #1;              // E0
    bus.start = 1'b0;
    repeat (4) @(posedge clk);       // E4
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.product} !== {2'b00, 16'h0000}) begin
      errors++; $display("FAIL reset_abort got busy/done/product=%b%b/%h want=00/0000", bus.busy, bus.done, bus.product);
    end
    #3 reset = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0) begin errors++; $display("FAIL no_done_after_reset active_cycles=%0d want=0", n_done); end
    run_op(1'b0, 8'd2, 8'd2, dc);
    checks++;
    if (dc != 9 || bus.product !== 16'h0004) begin
      errors++; $display("FAIL post_reset_2x2 got cyc=%0d product=%h want 9/0004", dc, bus.product);
    end
  endtask

  // start held high: accepts at E0 and E11, done at E9 and E20
  task automatic test_back_to_back();
    int d0;
    int d1;
    int n_done;
    logic busy10;
    logic busy11;
    d0 = -1; d1 = -1; n_done = 0; busy10 = 1'bx; busy11 = 1'bx;
    bus.signed_mode = 1'b0; bus.multiplicand = 8'd6; bus.multiplier = 8'd7; bus.start = 1'b1;
    for (int cyc = 0; cyc <= 24; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 12) bus.start = 1'b0;
      if (cyc == 10) busy10 = bus.busy;
      if (cyc == 11) busy11 = bus.busy;
      if (bus.done === 1'b1) begin
        n_done++;
        if (d0 < 0) d0 = cyc; else if (d1 < 0) d1 = cyc;
      end
    end
    checks++;
    if (n_done != 2 || d0 != 9 || d1 != 20) begin
      errors++; $display("FAIL b2b_done count=%0d at %0d,%0d want 2 at 9,20", n_done, d0, d1);
    end
    checks++;
    if ({busy10, busy11} !== 2'b01) begin errors++; $display("FAIL b2b_busy got E10/E11=%b%b want=01", busy10, busy11); end
    checks++;
    if (bus.product !== 16'h002A) begin errors++; $display("FAIL b2b_product got=%h want=002A", bus.product); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_timing_3x5();
    test_unsigned();
    test_signed();
    test_zero_and_hold();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
